// File: rtl/ibuf_rd_ctrl.sv
// ibuf_rd_ctrl: read sequencer for the image buffer SRAM.
// On a start command it issues a burst of consecutive word reads, absorbs the
// SRAM's one-cycle read latency in a pending flag, and buffers returned words
// in a 2-entry FIFO that feeds a valid/ready stream. Issue is throttled so
// buffered plus in-flight words never exceed two, which gives full
// backpressure without overflow and one word per cycle when m_ready stays high.
module ibuf_rd_ctrl #(
  parameter int WD    = 128,
  parameter int DEPTH = 64,
  parameter int WA    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rstn,
  // command side
  input  logic            start,
  input  logic [WA-1:0]   base_addr,
  input  logic [WA:0]     len,
  output logic            busy,
  output logic            done,
  // SRAM read port
  output logic            mem_cs,
  output logic            mem_we,
  output logic [WA-1:0]   mem_addr,
  input  logic [WD-1:0]   mem_dout,
  // output stream
  output logic            m_valid,
  input  logic            m_ready,
  output logic [WD-1:0]   m_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [WA:0] DEPTH_W = (WA+1)'(DEPTH);
  localparam logic [WA:0] CNT_ONE = (WA+1)'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic            busy_q, done_q;
  logic [WA-1:0]   base_q, base_d;
  logic [WA:0]     len_q, len_d;
  logic [WA:0]     issued_q, issued_d;
  logic            inflight_q;
  logic [WA-1:0]   addr_q, addr_d;

  // 2-entry output FIFO: head_q is the word presented on m_data
  logic [1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [WD-1:0]   head_q, head_d;
  logic [WD-1:0]   tail_q, tail_d;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic            pop;
  logic            push;
  logic [2:0]      occupancy;
  logic            issue;
  logic [WA:0]     addr_sum;
  logic [WA:0]     addr_wrap;
  logic            burst_end;

  assign pop  = (fifo_cnt_q != 2'd0) && m_ready;
  assign push = inflight_q;

  // Words that will be held or outstanding after this cycle's pop; an issue is
  // only allowed if it cannot push the total past the FIFO capacity.
  assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign issue = (state_q == ST_RUN) && (issued_q < len_q) && (occupancy < 3'd2);

  // Address arithmetic in WA+1 bits with one conditional subtract, so the
  // wrap is correct for depths that are not a power of two.
  assign addr_sum  = {1'b0, base_q} + issued_q;
  assign addr_wrap = (addr_sum >= DEPTH_W) ? (addr_sum - DEPTH_W) : addr_sum;

  // The burst is finished on the edge that takes the last word out of the
  // FIFO: everything issued, nothing in flight, FIFO empty after this cycle.
  assign burst_end = (issued_q == len_q) && !inflight_q && (fifo_cnt_d == 2'd0);

  // Outputs
  assign mem_cs   = issue;
  assign mem_we   = 1'b0;
  assign mem_addr = issue ? addr_wrap[WA-1:0] : addr_q;
  assign m_valid  = (fifo_cnt_q != 2'd0);
  assign m_data   = head_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // FIFO next-state: push from the SRAM return, pop on stream handshake
  // NOTE: every variable driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    unique case ({push, pop})
      2'b10: begin
        if (fifo_cnt_q == 2'd0) head_d = mem_dout;
        else                    tail_d = mem_dout;
        fifo_cnt_d = fifo_cnt_q + 2'd1;
      end
      2'b01: begin
        if (fifo_cnt_q == 2'd2) head_d = tail_q;
        fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
      2'b11: begin
        if (fifo_cnt_q == 2'd1) begin
          head_d = mem_dout;
        end else begin
          head_d = tail_q;
          tail_d = mem_dout;
        end
      end
      default: ;
    endcase
  end

  // Control next-state: FSM transitions, command latch, issue counter
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q;
    addr_d   = issue ? addr_wrap[WA-1:0] : addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          len_d    = len;
          issued_d = '0;
          state_d  = (len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue)     issued_d = issued_q + CNT_ONE;
        if (burst_end) state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Register all state; busy/done are registered decodes of the next state
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the FIFO storage is reset because m_data must read zero during
  // reset; the buffer is only two words, so this costs almost nothing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      addr_q     <= '0;
      fifo_cnt_q <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d == ST_RUN);
      done_q     <= (state_d == ST_DONE);
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      inflight_q <= issue;
      addr_q     <= addr_d;
      fifo_cnt_q <= fifo_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

endmodule

// File: tb/tb_ibuf_rd_ctrl.sv
// Testbench for ibuf_rd_ctrl: a behavioural SRAM with a one-cycle registered
// read, a monitor logging issues, handshakes and done pulses, and one task
// per scenario comparing the logs against hand-computed expectations.
module tb_ibuf_rd_ctrl;

  localparam int WD    = 128;
  localparam int DEPTH = 64;
  localparam int WA    = 6;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            start = 1'b0;
  logic [WA-1:0]   base_addr = '0;
  logic [WA:0]     len = '0;
  logic            busy, done;
  logic            mem_cs, mem_we;
  logic [WA-1:0]   mem_addr;
  logic [WD-1:0]   mem_dout = '0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [WD-1:0]   m_data;

  logic [WD-1:0]   mem [DEPTH];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [WA-1:0]   addr_log[$];
  int              cs_cyc[$];
  logic [WD-1:0]   rx_log[$];
  int              rx_cyc[$];
  int              done_cyc[$];
  int              done_busy_hi = 0;
  int              n_cs = 0;
  int              n_hs = 0;
  int              occ_viol = 0;

  ibuf_rd_ctrl #(.WD(WD), .DEPTH(DEPTH), .WA(WA)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
  );

  always #5 clk = ~clk;

  // SRAM model with registered address and cycle counter
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (mem_cs) mem_dout <= mem[mem_addr];
  end

  // Monitor at the falling edge, away from the active edge
  always @(negedge clk) begin
    if (mem_cs) begin
      addr_log.push_back(mem_addr);
      cs_cyc.push_back(cycle);
      if (n_cs - n_hs - int'(m_valid && m_ready) >= 2) occ_viol++;
      n_cs++;
    end
    if (m_valid && m_ready) begin
      rx_log.push_back(m_data);
      rx_cyc.push_back(cycle);
      n_hs++;
    end
    if (done) begin
      done_cyc.push_back(cycle);
      if (busy) done_busy_hi++;
    end
  end

  function automatic logic [WD-1:0] word_at(input int a);
    return WD'(256 + (a % DEPTH));
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    addr_log.delete();
    cs_cyc.delete();
    rx_log.delete();
    rx_cyc.delete();
    done_cyc.delete();
    done_busy_hi = 0;
    n_cs = 0;
    n_hs = 0;
    occ_viol = 0;
  endtask

  // Presents start for one edge; e0 is the number of the cycle after that edge
  task automatic do_start(input logic [WA-1:0] b, input logic [WA:0] l, output int e0);
    start = 1'b1;
    base_addr = b;
    len = l;
    tick();
    e0 = cycle;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while (done_cyc.size() == 0 && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (done_cyc.size() == 0) begin
      errors++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    start = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, mem_cs, mem_we, m_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, mem_cs, mem_we, m_valid});
    end
    checks++;
    if (mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr: got %0d expected 0", mem_addr);
    end
    checks++;
    if (m_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %0h expected 0", m_data);
    end
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || done_cyc.size() != 0 || n_cs != 0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b dones=%0d issues=%0d expected 0/0/0", busy, done_cyc.size(), n_cs);
    end
  endtask

  task automatic test_basic();
    int e0;
    clear_logs();
    m_ready = 1'b1;
    do_start(6'd0, 7'd4, e0);
    wait_done(40, "basic");
    repeat (3) tick();
    checks++;
    if (n_cs != 4 || rx_log.size() != 4) begin
      errors++;
      $display("FAIL basic_count: issues=%0d words=%0d expected 4/4", n_cs, rx_log.size());
    end
    for (int i = 0; i < 4 && i < addr_log.size() && i < rx_log.size(); i++) begin
      checks++;
      if (addr_log[i] !== WA'(i) || cs_cyc[i] != e0 + i) begin
        errors++;
        $display("FAIL basic_issue%0d: addr=%0d cyc=%0d expected addr=%0d cyc=%0d", i, addr_log[i], cs_cyc[i], i, e0 + i);
      end
      checks++;
      if (rx_log[i] !== word_at(i) || rx_cyc[i] != e0 + 2 + i) begin
        errors++;
        $display("FAIL basic_word%0d: data=%0h cyc=%0d expected data=%0h cyc=%0d", i, rx_log[i], rx_cyc[i], word_at(i), e0 + 2 + i);
      end
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != e0 + 6 || done_busy_hi != 0) begin
      errors++;
      $display("FAIL basic_done: pulses=%0d first_cyc=%0d busy_hi=%0d expected 1/%0d/0", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, done_busy_hi, e0 + 6);
    end
    checks++;
    if (mem_we !== 1'b0 || occ_viol != 0) begin
      errors++;
      $display("FAIL basic_we_occ: we=%b occ_viol=%0d expected 0/0", mem_we, occ_viol);
    end
  endtask

  task automatic test_wrap();
    int e0;
    clear_logs();
    m_ready = 1'b1;
    do_start(6'd62, 7'd4, e0);
    wait_done(40, "wrap");
    repeat (3) tick();
    checks++;
    if (n_cs != 4 || rx_log.size() != 4) begin
      errors++;
      $display("FAIL wrap_count: issues=%0d words=%0d expected 4/4", n_cs, rx_log.size());
    end
    for (int i = 0; i < 4 && i < addr_log.size() && i < rx_log.size(); i++) begin
      checks++;
      if (addr_log[i] !== WA'((62 + i) % 64) || rx_log[i] !== word_at(62 + i)) begin
        errors++;
        $display("FAIL wrap_%0d: addr=%0d data=%0h expected addr=%0d data=%0h", i, addr_log[i], rx_log[i], (62 + i) % 64, word_at(62 + i));
      end
    end
  endtask

  task automatic test_backpressure();
    int e0;
    int k;
    int cs_before;
    clear_logs();
    m_ready = 1'b1;
    do_start(6'd16, 7'd8, e0);
    k = 0;
    while (rx_log.size() < 2 && k < 20) begin
      tick();
      k++;
    end
    m_ready = 1'b0;
    cs_before = n_cs;
    checks++;
    if (cycle != e0 + 4 || cs_before != 4) begin
      errors++;
      $display("FAIL bp_entry: cyc=%0d issues=%0d expected cyc=%0d issues=4", cycle, cs_before, e0 + 4);
    end
    for (int s = 0; s < 5; s++) begin
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== word_at(18)) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b data=%0h expected valid=1 data=%0h", s, m_valid, m_data, word_at(18));
      end
      tick();
    end
    checks++;
    if (n_cs != cs_before || rx_log.size() != 2) begin
      errors++;
      $display("FAIL bp_stall: issues_in_stall=%0d words=%0d expected 0/2", n_cs - cs_before, rx_log.size());
    end
    m_ready = 1'b1;
    wait_done(60, "bp");
    repeat (3) tick();
    checks++;
    if (rx_log.size() != 8 || n_cs != 8 || done_cyc.size() != 1 || occ_viol != 0) begin
      errors++;
      $display("FAIL bp_totals: words=%0d issues=%0d dones=%0d occ_viol=%0d expected 8/8/1/0", rx_log.size(), n_cs, done_cyc.size(), occ_viol);
    end
    for (int i = 0; i < 8 && i < rx_log.size() && i < addr_log.size(); i++) begin
      checks++;
      if (rx_log[i] !== word_at(16 + i) || addr_log[i] !== WA'(16 + i)) begin
        errors++;
        $display("FAIL bp_word%0d: data=%0h addr=%0d expected data=%0h addr=%0d", i, rx_log[i], addr_log[i], word_at(16 + i), 16 + i);
      end
    end
  endtask

  task automatic test_len0_full();
    int e0;
    int bad;
    clear_logs();
    m_ready = 1'b1;
    do_start(6'd7, 7'd0, e0);
    repeat (4) tick();
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != e0 || n_cs != 0) begin
      errors++;
      $display("FAIL len0: dones=%0d first_cyc=%0d issues=%0d expected 1/%0d/0", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, n_cs, e0);
    end
    clear_logs();
    do_start(6'd10, 7'd64, e0);
    wait_done(200, "full");
    repeat (3) tick();
    checks++;
    if (n_cs != 64 || rx_log.size() != 64) begin
      errors++;
      $display("FAIL full_count: issues=%0d words=%0d expected 64/64", n_cs, rx_log.size());
    end
    checks++;
    if (addr_log.size() != 64 || addr_log[63] !== 6'd9) begin
      errors++;
      $display("FAIL full_last_addr: got %0d expected 9", (addr_log.size() > 0) ? int'(addr_log[addr_log.size() - 1]) : -1);
    end
    bad = 0;
    for (int i = 0; i < 64 && i < rx_log.size(); i++)
      if (rx_log[i] !== word_at(10 + i) || rx_cyc[i] != e0 + 2 + i) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_stream: %0d words wrong in data or timing, expected 0", bad);
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != e0 + 66) begin
      errors++;
      $display("FAIL full_done: dones=%0d first_cyc=%0d expected 1/%0d", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, e0 + 66);
    end
  endtask

  task automatic test_start_busy();
    int e0;
    int k;
    clear_logs();
    m_ready = 1'b1;
    do_start(6'd20, 7'd6, e0);
    repeat (2) tick();
    start = 1'b1;
    base_addr = 6'd40;
    len = 7'd2;
    tick();
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL busy_done_seen: done=%b expected 1", done);
    end
    // start presented during the DONE cycle must be dropped
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    checks++;
    if (n_cs != 6 || rx_log.size() != 6 || done_cyc.size() != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignored: issues=%0d words=%0d dones=%0d busy=%b expected 6/6/1/0", n_cs, rx_log.size(), done_cyc.size(), busy);
    end
    checks++;
    if (done_cyc.size() < 1 || done_cyc[0] != e0 + 8) begin
      errors++;
      $display("FAIL busy_done_cyc: got %0d expected %0d", (done_cyc.size() > 0) ? done_cyc[0] : -1, e0 + 8);
    end
    for (int i = 0; i < 6 && i < rx_log.size() && i < addr_log.size(); i++) begin
      checks++;
      if (rx_log[i] !== word_at(20 + i) || addr_log[i] !== WA'(20 + i)) begin
        errors++;
        $display("FAIL busy_word%0d: data=%0h addr=%0d expected data=%0h addr=%0d", i, rx_log[i], addr_log[i], word_at(20 + i), 20 + i);
      end
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    int k;
    clear_logs();
    m_ready = 1'b1;
    do_start(6'd0, 7'd8, e0);
    k = 0;
    while (rx_log.size() < 3 && k < 20) begin
      tick();
      k++;
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done, mem_cs, mem_we, m_valid} !== 5'b0 || mem_addr !== '0 || m_data !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: ctrl=%b addr=%0d data=%0h expected all 0", {busy, done, mem_cs, mem_we, m_valid}, mem_addr, m_data);
    end
    repeat (2) tick();
    rstn = 1'b1;
    repeat (4) tick();
    checks++;
    if (done_cyc.size() != 0 || busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_quiet: dones=%0d busy=%b valid=%b expected 0/0/0", done_cyc.size(), busy, m_valid);
    end
    clear_logs();
    do_start(6'd5, 7'd2, e0);
    wait_done(30, "rst_restart");
    repeat (3) tick();
    checks++;
    if (rx_log.size() != 2 || done_cyc.size() != 1 || n_cs != 2) begin
      errors++;
      $display("FAIL rst_restart_count: words=%0d dones=%0d issues=%0d expected 2/1/2", rx_log.size(), done_cyc.size(), n_cs);
    end
    for (int i = 0; i < 2 && i < rx_log.size() && i < addr_log.size(); i++) begin
      checks++;
      if (rx_log[i] !== word_at(5 + i) || addr_log[i] !== WA'(5 + i)) begin
        errors++;
        $display("FAIL rst_restart_word%0d: data=%0h addr=%0d expected data=%0h addr=%0d", i, rx_log[i], addr_log[i], word_at(5 + i), 5 + i);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WD'(256 + i);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0_full();
    test_start_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
